// File: rtl/cipher_pkg.sv
// Shared constants and state encoding for the mod-p cipher stream sequencer.
package cipher_pkg;
    localparam logic [7:0] NULL_CHAR   = 8'h00;
    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_CIPHER = 2'b10;
    localparam logic [7:0] P_MOD       = 8'd227;

    typedef enum logic [2:0] {IDLE, ARM, FETCH, ISSUE, WAIT, EMIT, DONE} state_t;
endpackage

// File: rtl/cipher_stream_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end
endmodule

// File: rtl/cipher_stream_ctrl.sv
// Byte-stream sequencer for the single-character cipher core: fetch, issue, wait with
// timeout, emit; a NULL byte ends the message.
module cipher_stream_ctrl
    import cipher_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       key_in,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_err,
    output logic             out_tmo,
    output logic [7:0]       core_ptxt,
    output logic [7:0]       core_key,
    output logic [1:0]       core_mode,
    input  logic [7:0]       core_ctxt,
    input  logic             core_ready,
    input  logic             core_err,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] char_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    state_t           state, state_nxt;
    logic [7:0]       key_q, byte_q;
    logic [TMR_W-1:0] timer;
    logic             key_ld, byte_ld, res_ld, res_err, res_tmo;
    logic [7:0]       res_data;
    logic             cnt_clr, char_inc, err_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_ld    = 1'b0;
        byte_ld   = 1'b0;
        res_ld    = 1'b0;
        res_data  = NULL_CHAR;
        res_err   = 1'b0;
        res_tmo   = 1'b0;
        cnt_clr   = 1'b0;
        char_inc  = 1'b0;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ARM;
                    key_ld    = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            ARM:   state_nxt = FETCH;
            FETCH: begin
                if (in_valid) begin
                    byte_ld   = 1'b1;
                    state_nxt = (in_data == NULL_CHAR) ? DONE : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // Core error outranks a simultaneous ready; timeout only when the core is silent.
                if (core_err) begin
                    state_nxt = EMIT;
                    res_ld    = 1'b1;
                    res_err   = 1'b1;
                    err_inc   = 1'b1;
                end else if (core_ready) begin
                    state_nxt = EMIT;
                    res_ld    = 1'b1;
                    res_data  = core_ctxt;
                end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt = EMIT;
                    res_ld    = 1'b1;
                    res_tmo   = 1'b1;
                    err_inc   = 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_nxt = FETCH;
                    char_inc  = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort freezes key, counts and result registers as they are.
        if (abort) begin
            state_nxt = IDLE;
            key_ld    = 1'b0;
            byte_ld   = 1'b0;
            res_ld    = 1'b0;
            cnt_clr   = 1'b0;
            char_inc  = 1'b0;
            err_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q    <= '0;
            byte_q   <= '0;
            timer    <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
            out_tmo  <= 1'b0;
        end else begin
            if (key_ld)  key_q  <= key_in;
            if (byte_ld) byte_q <= in_data;
            if (state == ISSUE) begin
                timer <= '0;
            end else if (state == WAIT) begin
                timer <= timer + 1'b1;
            end
            if (res_ld) begin
                out_data <= res_data;
                out_err  <= res_err;
                out_tmo  <= res_tmo;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_char_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (char_inc),
        .q   (char_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (err_inc),
        .q   (err_cnt)
    );

    assign in_ready  = (state == FETCH);
    assign out_valid = (state == EMIT);
    assign core_mode = ((state == ISSUE) || (state == WAIT)) ? MODE_CIPHER : MODE_IDLE;
    assign core_ptxt = byte_q;
    assign core_key  = key_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Bench for cipher_stream_ctrl: behavioural core model plus message-level reference model.
module tb_cipher_stream_ctrl;
    import cipher_pkg::*;

    localparam int CNT_W       = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, abort;
    logic [7:0]       key_in, in_data;
    logic             in_valid, in_ready;
    logic [7:0]       out_data;
    logic             out_valid, out_ready, out_err, out_tmo;
    logic [7:0]       core_ptxt, core_key, core_ctxt;
    logic [1:0]       core_mode;
    logic             core_ready, core_err;
    logic             busy, done;
    logic [CNT_W-1:0] char_cnt, err_cnt;

    int         checks = 0;
    int         errors = 0;
    logic       err_byte [256];
    logic       core_silent;
    logic [7:0] msg_q [$];

    cipher_stream_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .key_in(key_in),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_err(out_err), .out_tmo(out_tmo), .core_ptxt(core_ptxt), .core_key(core_key),
        .core_mode(core_mode), .core_ctxt(core_ctxt), .core_ready(core_ready),
        .core_err(core_err), .busy(busy), .done(done), .char_cnt(char_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cipher_ref(input logic [7:0] p, input logic [7:0] k);
        int d;
        d = (int'(p) - int'(k)) % int'(P_MOD);
        if (d < 0) d += int'(P_MOD);
        return 8'(d);
    endfunction

    // Core model: answers one cycle after seeing active mode; raises ready and err together on listed bytes.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_ready <= 1'b0;
            core_err   <= 1'b0;
            core_ctxt  <= 8'h00;
        end else if (core_mode == MODE_CIPHER && !core_silent) begin
            core_ready <= 1'b1;
            core_err   <= err_byte[core_ptxt];
            core_ctxt  <= cipher_ref(core_ptxt, core_key);
        end else begin
            core_ready <= 1'b0;
            core_err   <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_msg(input logic [7:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
        key_in = ~k;
        check("arm_key", core_key, k);
        check("arm_char_cnt", char_cnt, 0);
        check("arm_err_cnt", err_cnt, 0);
        check("arm_busy", busy, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv(input logic [7:0] ed, input logic ee, input logic et, input int stall);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("out_valid", out_valid, 1);
        check("out_data", out_data, ed);
        check("out_err", out_err, ee);
        check("out_tmo", out_tmo, et);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_data  = NULL_CHAR;
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, ed);
            check("stall_flags", {out_err, out_tmo}, {ee, et});
            check("stall_in_ready", in_ready, 0);
            check("stall_core_mode", core_mode, MODE_IDLE);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Message-level model: each non-NULL byte yields either an error byte or (P-K) mod 227.
    task automatic run_msg(input logic [7:0] k, input int smin, input int smax);
        int         nchar = 0;
        int         nerr  = 0;
        logic [7:0] b;
        start_msg(k);
        for (int i = 0; i < msg_q.size(); i++) begin
            b = msg_q[i];
            send_byte(b);
            if (b == NULL_CHAR) break;
            if (err_byte[b]) begin
                recv(8'h00, 1'b1, 1'b0, $urandom_range(smax, smin));
                if (nerr < CNT_MAX) nerr++;
            end else begin
                recv(cipher_ref(b, k), 1'b0, 1'b0, $urandom_range(smax, smin));
            end
            if (nchar < CNT_MAX) nchar++;
        end
        check("done_pulse", done, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("msg_char_cnt", char_cnt, nchar);
        check("msg_err_cnt", err_cnt, nerr);
        check("key_held", core_key, k);
    endtask

    initial begin
        int n;
        int len;
        rst = 1'b1; start = 1'b0; abort = 1'b0; key_in = 8'h00; in_data = 8'h00;
        in_valid = 1'b0; out_ready = 1'b0; core_silent = 1'b0;
        foreach (err_byte[i]) err_byte[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_core_mode", core_mode, MODE_IDLE);
        check("rst_core_key", core_key, 0);
        check("rst_counts", {char_cnt, err_cnt}, 0);

        msg_q = '{8'h41, 8'h00};
        run_msg(8'h10, 0, 0);
        check("t1_char_cnt", char_cnt, 1);
        check("t1_err_cnt", err_cnt, 0);

        msg_q = '{8'h05, 8'h00};
        run_msg(8'h10, 0, 0);

        err_byte[8'h62] = 1'b1;
        msg_q = '{8'h41, 8'h62, 8'h00};
        run_msg(8'h10, 0, 0);
        check("t3_char_cnt", char_cnt, 2);
        check("t3_err_cnt", err_cnt, 1);
        err_byte[8'h62] = 1'b0;

        core_silent = 1'b1;
        start_msg(8'h10);
        send_byte(8'h41);
        n = 0;
        while (!out_valid && n < 100) begin
            if (core_mode == MODE_CIPHER) n++;
            @(negedge clk);
        end
        check("t4_issue_plus_wait_cycles", n, TIMEOUT_CYC + 1);
        recv(8'h00, 1'b0, 1'b1, 0);
        core_silent = 1'b0;
        send_byte(NULL_CHAR);
        check("t4_done", done, 1);
        @(negedge clk);
        check("t4_char_cnt", char_cnt, 1);
        check("t4_err_cnt", err_cnt, 1);

        msg_q = '{8'h33, 8'h00};
        run_msg(8'h07, 5, 5);

        start_msg(8'h22);
        send_byte(8'h41);
        recv(cipher_ref(8'h41, 8'h22), 1'b0, 1'b0, 0);
        core_silent = 1'b1;
        send_byte(8'h50);
        @(negedge clk);
        check("t6_in_wait", core_mode, MODE_CIPHER);
        abort = 1'b1; start = 1'b1; key_in = 8'h99;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("t6_abort_busy", busy, 0);
        check("t6_abort_mode", core_mode, MODE_IDLE);
        check("t6_abort_no_done", done, 0);
        check("t6_abort_ready", {in_ready, out_valid}, 0);
        check("t6_char_held", char_cnt, 1);
        check("t6_key_held", core_key, 8'h22);
        @(negedge clk);
        check("t6_still_idle", busy, 0);
        check("t6_no_late_done", done, 0);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        check("t6_idle_abort_wins", busy, 0);
        core_silent = 1'b0;
        msg_q = '{8'h20, 8'h00};
        run_msg(8'h33, 0, 0);

        core_silent = 1'b1;
        start_msg(8'h44);
        send_byte(8'h12);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mode", core_mode, MODE_IDLE);
        check("arst_key", core_key, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        core_silent = 1'b0;
        @(negedge clk);
        check("arst_no_done", done, 0);

        for (int r = 0; r < 8; r++) begin
            foreach (err_byte[i]) err_byte[i] = ($urandom_range(9, 0) == 0);
            msg_q.delete();
            len = $urandom_range(12, 1);
            repeat (len) msg_q.push_back(8'($urandom_range(255, 1)));
            msg_q.push_back(NULL_CHAR);
            run_msg(8'($urandom), 0, 3);
        end

        foreach (err_byte[i]) err_byte[i] = ($urandom_range(9, 0) == 0);
        msg_q.delete();
        repeat (CNT_MAX + 5) msg_q.push_back(8'($urandom_range(255, 1)));
        msg_q.push_back(NULL_CHAR);
        run_msg(8'($urandom), 0, 0);
        check("sat_char_cnt", char_cnt, CNT_MAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
